// File: rtl/jt51_slot_seq.sv
// Slot sequencer: walks the 32 operator slots, looks up each channel's
// connection/feedback and decodes the modulation-source selects.
module jt51_slot_seq #(
  parameter int FB_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr_en,
  input  logic [2:0] wr_ch,
  input  logic [2:0] wr_con,
  input  logic [2:0] wr_fb,
  output logic [4:0] slot,
  output logic [2:0] con_I,
  output logic [2:0] fb_II,
  output logic       m1_enters,
  output logic       c1_enters,
  output logic       use_prevprev1,
  output logic       use_internal_x,
  output logic       use_prev2,
  output logic       use_prev1,
  output logic       use_internal_y,
  output logic       zero
);

  // Select vector order: {prevprev1, internal_x, prev2, prev1, internal_y}
  function automatic logic [4:0] use_decode(input logic [1:0] grp, input logic [2:0] con);
    logic [4:0] u;
    u = 5'b00000;
    case (grp)
      2'd0: u = 5'b10010;
      2'd1: begin
        case (con)
          3'd0:    u = 5'b00010;
          3'd1:    u = 5'b10010;
          3'd2:    u = 5'b00010;
          3'd5:    u = 5'b10000;
          default: u = 5'b00000;
        endcase
      end
      2'd2: begin
        case (con)
          3'd0, 3'd3, 3'd4, 3'd5, 3'd6: u = 5'b10000;
          default:                      u = 5'b00000;
        endcase
      end
      2'd3: begin
        case (con)
          3'd0, 3'd1: u = 5'b00100;
          3'd2:       u = 5'b00101;
          3'd3:       u = 5'b00110;
          3'd4:       u = 5'b00001;
          3'd5:       u = 5'b10000;
          default:    u = 5'b00000;
        endcase
      end
      default: u = 5'b00000;
    endcase
    return u;
  endfunction

  logic [4:0] cnt_r;
  logic [5:0] ch_tab_r [8];
  logic [2:0] fb_sr_r [FB_LAT+1];
  logic [5:0] rd_ent_s;
  logic [4:0] use_nxt_s;

  assign rd_ent_s  = ch_tab_r[cnt_r[2:0]];
  assign use_nxt_s = use_decode(cnt_r[4:3], rd_ent_s[5:3]);
  assign fb_II     = fb_sr_r[FB_LAT];

  // Channel table: writes land regardless of cen; reads see the pre-write value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) ch_tab_r[i] <= 6'd0;
    end else if (wr_en) begin
      ch_tab_r[wr_ch] <= {wr_con, wr_fb};
    end
  end

  // Slot counter, registered decode outputs and feedback delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r          <= 5'd0;
      slot           <= 5'd0;
      con_I          <= 3'd0;
      m1_enters      <= 1'b0;
      c1_enters      <= 1'b0;
      zero           <= 1'b0;
      use_prevprev1  <= 1'b0;
      use_internal_x <= 1'b0;
      use_prev2      <= 1'b0;
      use_prev1      <= 1'b0;
      use_internal_y <= 1'b0;
      for (int i = 0; i <= FB_LAT; i++) fb_sr_r[i] <= 3'd0;
    end else if (cen) begin
      cnt_r      <= cnt_r + 5'd1;
      slot       <= cnt_r;
      con_I      <= rd_ent_s[5:3];
      m1_enters  <= (cnt_r[4:3] == 2'd0);
      c1_enters  <= (cnt_r[4:3] == 2'd2);
      zero       <= (cnt_r == 5'd0);
      {use_prevprev1, use_internal_x, use_prev2, use_prev1, use_internal_y} <= use_nxt_s;
      fb_sr_r[0] <= rd_ent_s[2:0];
      for (int i = 1; i <= FB_LAT; i++) fb_sr_r[i] <= fb_sr_r[i-1];
    end
  end

endmodule

// File: doc/jt51_slot_seq.md
JT51_SLOT_SEQ -- requirements
Module: jt51_slot_seq

Interface
REQ-001 SHALL have parameter FB_LAT, default 1; it is the number of cen stages by which fb_II lags con_I, with legal range 1..3.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have cen, input, 1 bit: slot-advance enable.
REQ-005 SHALL have wr_en, input, 1 bit: channel-table write strobe.
REQ-006 SHALL have wr_ch, input, 3 bits: channel written.
REQ-007 SHALL have wr_con, input, 3 bits: connection (algorithm) value written.
REQ-008 SHALL have wr_fb, input, 3 bits: feedback value written.
REQ-009 SHALL have slot, output, 5 bits: the slot described by all other outputs.
REQ-010 SHALL have con_I, output, 3 bits: connection value of the current slot's channel.
REQ-011 SHALL have fb_II, output, 3 bits: feedback value of the channel, delayed FB_LAT cen stages.
REQ-012 SHALL have m1_enters and c1_enters, outputs, 1 bit each: operator-group flags.
REQ-013 SHALL have use_prevprev1, use_internal_x, use_prev2, use_prev1 and use_internal_y, outputs, 1 bit each: modulation source selects.
REQ-014 SHALL have zero, output, 1 bit: slot-0 marker.

Function
REQ-015 SHALL hold an 8-entry table of {con, fb}, 6 bits per entry, indexed by channel.
REQ-016 SHALL write the table entry on any clk edge with wr_en=1, independent of cen.
REQ-017 SHALL hold an internal 5-bit slot counter cnt that increments on each cen edge and wraps from 31 to 0.
REQ-018 SHALL update all outputs only on cen edges, from decode(cnt) and the table value read at that edge; outputs therefore lag cnt by one cen.
REQ-019 SHALL load slot<=cnt on each cen edge.
REQ-020 SHALL take group=slot[4:3] (0=M1, 1=M2, 2=C1, 3=C2) and ch=slot[2:0].
REQ-021 SHALL drive m1_enters=(group==0), c1_enters=(group==2) and zero=(slot==0).
REQ-022 SHALL read the table pre-write on a same-edge write and read of one channel; the new value appears at that channel's next visit.
REQ-023 SHALL drive the use_* vector, written {use_prevprev1, use_internal_x, use_prev2, use_prev1, use_internal_y}, per group and con:
  - M1, any con: 10010.
  - M2: con0 00010; con1 10010; con2 00010; con5 10000; con3/4/6/7 00000.
  - C1: con0/3/4/5/6 10000; con1/2/7 00000.
  - C2: con0/1 00100; con2 00101; con3 00110; con4 00001; con5 10000; con6/7 00000.
REQ-024 SHALL keep the x-selects (use_prevprev1, use_internal_x, use_prev2) one-hot-or-zero, and the y-selects (use_prev1, use_internal_y) likewise.
REQ-025 SHALL set con_I to the table con of ch, captured at the same edge as slot.
REQ-026 SHALL make fb_II equal to the table fb captured with con_I, delayed FB_LAT further cen edges through a shift register.
REQ-027 SHALL freeze cnt, the outputs and the fb shift register while cen=0; table writes still occur.
REQ-028 SHALL leave cnt and the output sequence unaffected by any write.

Reset
REQ-029 SHALL clear, while rst_n=0, cnt=0, slot=0, all table entries=0, con_I=0, fb_II=0, the fb shift register=0, and all flags including zero=0, immediately and without a clock.
REQ-030 SHALL, on the first cen edge after rst_n rises, present slot=0, zero=1, m1_enters=1 and use_* vector=10010.
REQ-031 SHALL restart the slot sequence from REQ-030 when reset is asserted mid-frame, and discard all table contents.

Verification
REQ-032 SHALL cover: reset, then 33 cen pulses -> slot sequence 0,1..31,0; zero high only at slot 0; m1_enters high for slots 0-7; c1_enters high for slots 16-23.
REQ-033 SHALL cover: write ch3 con=2 fb=5, then run to slot 27 -> use_* vector=00101 and con_I=2; with FB_LAT=1, fb_II=5 one cen later (at slot 28).
REQ-034 SHALL cover: all 8 con values on ch0 at slots 0, 8, 16 and 24 -> the use_* vector matches the REQ-023 table; no x-select or y-select conflict.
REQ-035 SHALL cover: cen held low for 10 clk with a write to ch1 meanwhile -> outputs unchanged; the new ch1 value appears at the next slot 1, 9, 17 or 25.
REQ-036 SHALL cover: a same-edge write and read of ch4 at slot 12 -> the old con is shown at slot 12; the new con is shown at slot 20.
REQ-037 SHALL cover: rst_n pulsed low at slot 19 -> all outputs 0 at once; after release, the first cen gives slot=0 and zero=1, and con_I=0 for all channels.
